// File: rtl/cau_sequencer.sv
// cau_sequencer: frame controller for the convolution accelerator unit.
// It loads the kernel once per frame, then for every valid 3x3 window it
// fetches nine pixels, issues the packed window as a scope word, waits for
// the CAU result and presents it on a valid/ready output stream.
//
// Handshake: a result transfers on any rising clk edge where out_valid and
// out_ready are both high. While out_valid is high, out_data and out_addr
// stay stable and out_valid stays high until that transfer happens.
module cau_sequencer #(
  parameter int         IMG_W     = 8,
  parameter int         IMG_H     = 8,
  parameter int         ADDR_W    = 12,
  parameter int         CAU_LAT   = 1,
  parameter logic [1:0] OP_KERNEL = 2'b00,
  parameter logic [1:0] OP_SCOPE  = 2'b01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [71:0]       kernel_in,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic              cau_select,
  output logic [1:0]        cau_opcode,
  output logic [71:0]       cau_data,
  input  logic [17:0]       cau_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [17:0]       out_data,
  output logic [2:0]        dbg_state
);

  localparam int XW      = $clog2(IMG_W);
  localparam int YW      = $clog2(IMG_H);
  localparam int CNT_MAX = (CAU_LAT > 10) ? CAU_LAT : 10;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [XW-1:0]     LAST_X   = XW'(IMG_W - 3);
  localparam logic [YW-1:0]     LAST_Y   = YW'(IMG_H - 3);
  // Jump from the right column of one window row to the left column of the next.
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADK = 3'd1,
    S_FETCH = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_EMIT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;
  logic                cau_select_q, cau_select_d;
  logic [1:0]          cau_opcode_q, cau_opcode_d;
  // cau_data_q doubles as the kernel latch: it holds kernel_in from the
  // accepted start through the LOADK cycle.
  logic [71:0]         cau_data_q, cau_data_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [17:0]         out_data_q, out_data_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   base_q, base_d;   // y*IMG_W + x of the window origin
  logic [ADDR_W-1:0]   oidx_q, oidx_d;   // y*(IMG_W-2) + x of the window
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // FETCH cycle / WAIT cycle
  logic [1:0]          col_q, col_d;     // column j of the read in flight
  logic [71:0]         window_q, window_d;
  logic [ADDR_W-1:0]   nxt_base;

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign cau_select  = cau_select_q;
  assign cau_opcode  = cau_opcode_q;
  assign cau_data    = cau_data_q;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;
  assign dbg_state   = state_q;

  // Next-state and registered-output logic; outputs are set up one cycle
  // ahead so they are valid for the whole cycle of the state they belong to.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    mem_rd_en_d   = 1'b0;
    mem_rd_addr_d = mem_rd_addr_q;
    cau_select_d  = 1'b0;
    cau_opcode_d  = cau_opcode_q;
    cau_data_d    = cau_data_q;
    out_valid_d   = out_valid_q;
    out_addr_d    = out_addr_q;
    out_data_d    = out_data_q;
    x_d           = x_q;
    y_d           = y_q;
    base_d        = base_q;
    oidx_d        = oidx_q;
    cnt_d         = cnt_q;
    col_d         = col_q;
    window_d      = window_q;
    nxt_base      = base_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOADK;
          busy_d       = 1'b1;
          cau_select_d = 1'b1;
          cau_opcode_d = OP_KERNEL;
          cau_data_d   = kernel_in;
          x_d          = '0;
          y_d          = '0;
          base_d       = '0;
          oidx_d       = '0;
        end
      end

      S_LOADK: begin
        state_d       = S_FETCH;
        mem_rd_en_d   = 1'b1;
        mem_rd_addr_d = base_q;
        cnt_d         = '0;
        col_d         = '0;
      end

      S_FETCH: begin
        // Byte k arrives one cycle after its read, i.e. in FETCH cycle k+1.
        for (int k = 0; k < 8; k++) begin
          if (cnt_q == CNT_W'(k + 1)) window_d[8*k +: 8] = mem_rd_data;
        end
        if (cnt_q < CNT_W'(8)) begin
          mem_rd_en_d   = 1'b1;
          mem_rd_addr_d = (col_q == 2'd2) ? mem_rd_addr_q + ROW_STEP
                                          : mem_rd_addr_q + ADDR_W'(1);
          col_d         = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
        end
        if (cnt_q == CNT_W'(9)) begin
          window_d[71:64] = mem_rd_data;
          state_d         = S_ISSUE;
          cau_select_d    = 1'b1;
          cau_opcode_d    = OP_SCOPE;
          cau_data_d      = {mem_rd_data, window_q[63:0]};
          cnt_d           = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end

      S_WAIT: begin
        if (cnt_q == CNT_W'(CAU_LAT - 1)) begin
          state_d     = S_EMIT;
          out_valid_d = 1'b1;
          out_data_d  = cau_result;
          out_addr_d  = oidx_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          oidx_d      = oidx_q + ADDR_W'(1);
          if (x_q == LAST_X) begin
            x_d      = '0;
            y_d      = y_q + YW'(1);
            nxt_base = base_q + ADDR_W'(3);
          end else begin
            x_d      = x_q + XW'(1);
            nxt_base = base_q + ADDR_W'(1);
          end
          base_d = nxt_base;
          if (x_q == LAST_X && y_q == LAST_Y) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d       = S_FETCH;
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = nxt_base;
            cnt_d         = '0;
            col_d         = '0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      cau_select_q  <= 1'b0;
      cau_opcode_q  <= 2'b00;
      cau_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= '0;
      out_data_q    <= '0;
      x_q           <= '0;
      y_q           <= '0;
      base_q        <= '0;
      oidx_q        <= '0;
      cnt_q         <= '0;
      col_q         <= '0;
      window_q      <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      cau_select_q  <= cau_select_d;
      cau_opcode_q  <= cau_opcode_d;
      cau_data_q    <= cau_data_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
      out_data_q    <= out_data_d;
      x_q           <= x_d;
      y_q           <= y_d;
      base_q        <= base_d;
      oidx_q        <= oidx_d;
      cnt_q         <= cnt_d;
      col_q         <= col_d;
      window_q      <= window_d;
    end
  end

endmodule

// File: tb/tb_cau_sequencer.sv
// Bench for cau_sequencer on a 4x4 image whose pixel value equals its
// address. Instance 0 uses CAU_LAT=1, instance 1 uses CAU_LAT=3; the two
// never run at the same time and share one expected-result queue.
module tb_cau_sequencer;

  localparam int         W    = 4;
  localparam int         H    = 4;
  localparam int         AW   = 12;
  localparam logic [1:0] OP_K = 2'b00;
  localparam logic [1:0] OP_S = 2'b01;
  localparam logic [71:0] K_ONES  = 72'h010101010101010101;
  localparam logic [71:0] K_IDENT = 72'h000000000100000000;
  localparam logic [71:0] K_OTHER = 72'h020202020202020202;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start_s [2];
  logic [71:0]   kin     [2];
  logic          busy    [2];
  logic          done    [2];
  logic          rd_en   [2];
  logic [AW-1:0] rd_addr [2];
  logic [7:0]    rd_data [2];
  logic          sel     [2];
  logic [1:0]    opc     [2];
  logic [71:0]   cdata   [2];
  logic [17:0]   cres    [2];
  logic          ovalid  [2];
  logic          oready  [2];
  logic [AW-1:0] oaddr   [2];
  logic [17:0]   odata   [2];
  logic [2:0]    dstate  [2];

  cau_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CAU_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .kernel_in(kin[0]),
    .busy(busy[0]), .done(done[0]), .mem_rd_en(rd_en[0]),
    .mem_rd_addr(rd_addr[0]), .mem_rd_data(rd_data[0]),
    .cau_select(sel[0]), .cau_opcode(opc[0]), .cau_data(cdata[0]),
    .cau_result(cres[0]), .out_valid(ovalid[0]), .out_ready(oready[0]),
    .out_addr(oaddr[0]), .out_data(odata[0]), .dbg_state(dstate[0])
  );

  cau_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CAU_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .kernel_in(kin[1]),
    .busy(busy[1]), .done(done[1]), .mem_rd_en(rd_en[1]),
    .mem_rd_addr(rd_addr[1]), .mem_rd_data(rd_data[1]),
    .cau_select(sel[1]), .cau_opcode(opc[1]), .cau_data(cdata[1]),
    .cau_result(cres[1]), .out_valid(ovalid[1]), .out_ready(oready[1]),
    .out_addr(oaddr[1]), .out_data(odata[1]), .dbg_state(dstate[1])
  );

  // ---------------- memory and CAU models ----------------
  logic [71:0] mkern [2];
  logic [17:0] p0 [2];
  logic [17:0] p1 [2];
  logic [17:0] p2 [2];

  function automatic logic [17:0] dot9(input logic [71:0] a, input logic [71:0] b);
    logic [17:0] s;
    s = '0;
    for (int k = 0; k < 9; k++) s = s + 18'(a[8*k +: 8]) * 18'(b[8*k +: 8]);
    return s;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sel[d] && opc[d] == OP_K) mkern[d] <= cdata[d];
      p0[d] <= dot9(mkern[d], cdata[d]);
      p1[d] <= p0[d];
      p2[d] <= p1[d];
      rd_data[d] <= rd_en[d] ? rd_addr[d][7:0] : 8'h00;
    end
  end

  always_comb begin
    cres[0] = p0[0];
    cres[1] = p2[1];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  logic [29:0]   exp_q[$];   // {out_addr[11:0], out_data[17:0]}
  logic [AW-1:0] rd_log[$];
  logic [29:0]   e;
  int acc_cnt   = 0;
  int done_cnt  = 0;
  int loadk_cnt = 0;
  int issue_cyc [2];
  int spacing   [2];
  logic pv      [2];

  function automatic logic [17:0] win_val(input logic [71:0] k, input int x, input int y);
    logic [17:0] s;
    s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s = s + 18'(k[8*(3*i+j) +: 8]) * 18'((y + i) * W + (x + j));
    return s;
  endfunction

  task automatic push_frame(input logic [71:0] k);
    for (int y = 0; y < H - 2; y++)
      for (int x = 0; x < W - 2; x++)
        exp_q.push_back({12'(y * (W - 2) + x), win_val(k, x, y)});
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ovalid[d] && oready[d]) begin
        if (exp_q.size() == 0) check("result_expected", 32'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          check("out_addr", 32'(oaddr[d]), 32'(e[29:18]));
          check("out_data", 32'(odata[d]), 32'(e[17:0]));
        end
        acc_cnt++;
      end
      if (done[d]) done_cnt++;
      if (sel[d] && opc[d] == OP_K) loadk_cnt++;
      if (sel[d] && opc[d] == OP_S) issue_cyc[d] = cyc;
      if (ovalid[d] && !pv[d]) spacing[d] = cyc - issue_cyc[d];
      pv[d] = ovalid[d];
      if (rd_en[d] && rd_log.size() < 9) rd_log.push_back(rd_addr[d]);
    end
  end

  // ---------------- driver tasks ----------------
  int done_base, loadk_base;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int d, input logic [71:0] k);
    kin[d]     = k;
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
  endtask

  task automatic start_frame(input int d, input logic [71:0] k);
    push_frame(k);
    done_base  = done_cnt;
    loadk_base = loadk_cnt;
    rd_log.delete();
    pulse_start(d, k);
  endtask

  task automatic finish_frame(input int d);
    int n;
    n = 0;
    while (!done[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_in_budget", 32'(done[d]), 1);
    @(negedge clk);
    check("busy_after_done", 32'(busy[d]), 0);
    check("done_one_cycle", 32'(done[d]), 0);
    check("done_pulses", 32'(done_cnt - done_base), 1);
    check("loadk_cycles", 32'(loadk_cnt - loadk_base), 1);
    check("results_left", 32'(exp_q.size()), 0);
    tick();
  endtask

  task automatic check_idle(input int d);
    check("rst_busy",      32'(busy[d]), 0);
    check("rst_done",      32'(done[d]), 0);
    check("rst_rd_en",     32'(rd_en[d]), 0);
    check("rst_rd_addr",   32'(rd_addr[d]), 0);
    check("rst_cau_sel",   32'(sel[d]), 0);
    check("rst_cau_op",    32'(opc[d]), 0);
    check("rst_cau_data",  32'(|cdata[d]), 0);
    check("rst_out_valid", 32'(ovalid[d]), 0);
    check("rst_out_addr",  32'(oaddr[d]), 0);
    check("rst_out_data",  32'(odata[d]), 0);
    check("rst_state",     32'(dstate[d]), 0);
  endtask

  task automatic wait_accepts(input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_budget", 32'(acc_cnt >= target), 1);
  endtask

  // ---------------- stimulus ----------------
  int exp_rd [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

  initial begin
    int n;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      kin[d]     = '0;
      oready[d]  = 1'b1;
    end
    repeat (3) tick();
    check_idle(0);
    check_idle(1);
    rst = 1'b1;
    repeat (2) tick();

    // All-ones kernel: 45, 54, 81, 90.
    start_frame(0, K_ONES);
    finish_frame(0);
    check("issue_to_valid_lat1", 32'(spacing[0]), 2);

    // Identity kernel: centre pixels 5, 6, 9, 10; first window read order.
    start_frame(0, K_IDENT);
    finish_frame(0);
    check("rd_log_len", 32'(rd_log.size()), 9);
    for (int k = 0; k < 9 && k < rd_log.size(); k++)
      check("rd_addr_win0", 32'(rd_log[k]), 32'(exp_rd[k]));

    // Backpressure on result 1.
    start_frame(0, K_ONES);
    wait_accepts(acc_cnt + 1);
    tick();
    oready[0] = 1'b0;
    n = 0;
    while (!ovalid[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(ovalid[0]), 1);
      check("bp_data",  32'(odata[0]), 54);
      check("bp_addr",  32'(oaddr[0]), 1);
      check("bp_rd_en", 32'(rd_en[0]), 0);
      @(negedge clk);
    end
    tick();
    oready[0] = 1'b1;
    finish_frame(0);

    // Start while busy is ignored.
    start_frame(0, K_ONES);
    repeat (20) tick();
    check("busy_mid_frame", 32'(busy[0]), 1);
    pulse_start(0, K_OTHER);
    finish_frame(0);

    // Reset in the middle of the second window's fetch.
    start_frame(0, K_ONES);
    wait_accepts(acc_cnt + 1);
    repeat (3) tick();
    check("state_before_rst", 32'(dstate[0]), 2);
    rst = 1'b0;
    #1;
    check_idle(0);
    exp_q.delete();
    done_base = done_cnt;
    repeat (20) tick();
    check("no_done_after_rst", 32'(done_cnt - done_base), 0);
    rst = 1'b1;
    tick();
    start_frame(0, K_ONES);
    finish_frame(0);

    // CAU_LAT = 3 instance.
    start_frame(1, K_ONES);
    finish_frame(1);
    check("issue_to_valid_lat3", 32'(spacing[1]), 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
